five_stage_hazard_unit: RTL and testbench

//  Hazard producer for the five-stage pipeline: watches decode/execute/memory stage fields and the
//  I/D memory handshakes, and drives true_data_hazard, d_mem_hazard, i_mem_hazard, JALR_branch_hazard
//  and JAL_hazard into the stall unit. Tracks outstanding memory transactions with wait FSMs and

---
 rtl/five_stage_hazard_pkg.sv | 15 +
 rtl/five_stage_hazard_unit_mem_wait_tracker.sv | 46 ++++
 rtl/five_stage_hazard_unit.sv | 72 +++++++
 tb/tb_five_stage_hazard_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/five_stage_hazard_pkg.sv
// five_stage_hazard_pkg: shared types and constants for the pipeline hazard unit
package five_stage_hazard_pkg;
  typedef enum logic {IDLE, WAIT} wait_state_t;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  function automatic logic load_use(
    input logic valid,
    input logic mem_read,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs1,
    input logic [REG_IDX_W-1:0] rs2
  );
    return valid & mem_read & (rd != REG_ZERO) & ((rd == rs1) | (rd == rs2));
  endfunction
endpackage

// File: rtl/five_stage_hazard_unit_mem_wait_tracker.sv
// mem_wait_tracker: per-side outstanding-transaction FSM with timeout watchdog
module mem_wait_tracker
  import five_stage_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic resp_valid,
  output logic hazard,
  output logic timeout_pulse
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  wait_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic expired;
  always_comb begin
    expired = (state_q == WAIT) & (cnt_q == CNT_MAX) & ~resp_valid;
    timeout_pulse = expired;
    state_d = state_q;
    cnt_d = cnt_q;
    hazard = 1'b0;
    if (state_q == IDLE) begin
      hazard = req & ~resp_valid;
      state_d = hazard ? WAIT : IDLE;
      cnt_d = hazard ? CNT_ONE : '0;
    end else begin
      // a completed, expired or flushed transaction all return to IDLE with a cleared counter
      hazard = ~resp_valid & ~expired;
      state_d = (resp_valid | expired | ~req) ? IDLE : WAIT;
      cnt_d = (resp_valid | expired | ~req) ? '0 : cnt_q + CNT_ONE;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/five_stage_hazard_unit.sv
// five_stage_hazard_unit: load-use, control and memory-wait hazards; HAZARD_STATS_EN adds cycle counters
module five_stage_hazard_unit
  import five_stage_hazard_pkg::*;
#(
  parameter int CORE = 0,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 decode_valid,
  input  logic [REG_IDX_W-1:0] decode_rs1,
  input  logic [REG_IDX_W-1:0] decode_rs2,
  input  logic                 decode_jal,
  input  logic [REG_IDX_W-1:0] execute_rd,
  input  logic                 execute_mem_read,
  input  logic                 execute_branch_taken,
  input  logic                 execute_jalr,
  input  logic                 i_mem_req,
  input  logic                 i_mem_resp_valid,
  input  logic                 d_mem_req,
  input  logic                 d_mem_resp_valid,
  output logic                 true_data_hazard,
  output logic                 d_mem_hazard,
  output logic                 i_mem_hazard,
  output logic                 JALR_branch_hazard,
  output logic                 JAL_hazard,
`ifdef HAZARD_STATS_EN
  output logic [CNT_WIDTH-1:0] stat_load_use,
  output logic [CNT_WIDTH-1:0] stat_d_wait,
  output logic [CNT_WIDTH-1:0] stat_i_wait,
  output logic [CNT_WIDTH-1:0] stat_ctrl,
`endif
  output logic [1:0]           mem_timeout_error
);
  logic i_to, d_to;
  logic [1:0] err_q;
  // CORE only tags scan/debug; CNT_WIDTH matters only with statistics enabled
  if (CORE < 0 || CNT_WIDTH < 1) begin : g_param_chk
  end
  assign true_data_hazard = load_use(decode_valid, execute_mem_read, execute_rd, decode_rs1, decode_rs2);
  assign JALR_branch_hazard = execute_branch_taken | execute_jalr;
  assign JAL_hazard = decode_valid & decode_jal;
  assign mem_timeout_error = err_q;
  mem_wait_tracker #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_i_wait (
    .clock(clock), .reset(reset), .req(i_mem_req), .resp_valid(i_mem_resp_valid),
    .hazard(i_mem_hazard), .timeout_pulse(i_to)
  );
  mem_wait_tracker #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_d_wait (
    .clock(clock), .reset(reset), .req(d_mem_req), .resp_valid(d_mem_resp_valid),
    .hazard(d_mem_hazard), .timeout_pulse(d_to)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 2'b00;
    else err_q <= err_q | {d_to, i_to};
  end
`ifdef HAZARD_STATS_EN
  logic [3:0] ev;
  logic [CNT_WIDTH-1:0] stat_q [4];
  assign ev = {JALR_branch_hazard | JAL_hazard, i_mem_hazard, d_mem_hazard, true_data_hazard};
  for (genvar g = 0; g < 4; g++) begin : g_stat
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) stat_q[g] <= '0;
      else if (ev[g] && !(&stat_q[g])) stat_q[g] <= stat_q[g] + 1'b1;
    end
  end
  assign stat_load_use = stat_q[0];
  assign stat_d_wait = stat_q[1];
  assign stat_i_wait = stat_q[2];
  assign stat_ctrl = stat_q[3];
`endif
endmodule

// File: tb/tb_five_stage_hazard_unit.sv
// tb_five_stage_hazard_unit: directed vectors against hand-computed hazard, watchdog and stats values
module tb_five_stage_hazard_unit;
  import five_stage_hazard_pkg::*;
  logic clock = 1'b0, reset = 1'b0;
  logic decode_valid = 0, decode_jal = 0, execute_mem_read = 0, execute_branch_taken = 0, execute_jalr = 0;
  logic [4:0] decode_rs1 = 0, decode_rs2 = 0, execute_rd = 0;
  logic i_mem_req = 0, i_mem_resp_valid = 0, d_mem_req = 0, d_mem_resp_valid = 0;
  logic true_data_hazard, d_mem_hazard, i_mem_hazard, JALR_branch_hazard, JAL_hazard;
  logic [1:0] mem_timeout_error;
`ifdef HAZARD_STATS_EN
  logic [3:0] stat_load_use, stat_d_wait, stat_i_wait, stat_ctrl;
`endif
  int vectors = 0, miscompares = 0;
  always #5 clock = ~clock;
  five_stage_hazard_unit #(.CORE(0), .MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .decode_valid(decode_valid), .decode_rs1(decode_rs1),
    .decode_rs2(decode_rs2), .decode_jal(decode_jal), .execute_rd(execute_rd),
    .execute_mem_read(execute_mem_read), .execute_branch_taken(execute_branch_taken),
    .execute_jalr(execute_jalr), .i_mem_req(i_mem_req), .i_mem_resp_valid(i_mem_resp_valid),
    .d_mem_req(d_mem_req), .d_mem_resp_valid(d_mem_resp_valid),
    .true_data_hazard(true_data_hazard), .d_mem_hazard(d_mem_hazard), .i_mem_hazard(i_mem_hazard),
    .JALR_branch_hazard(JALR_branch_hazard), .JAL_hazard(JAL_hazard),
`ifdef HAZARD_STATS_EN
    .stat_load_use(stat_load_use), .stat_d_wait(stat_d_wait), .stat_i_wait(stat_i_wait),
    .stat_ctrl(stat_ctrl),
`endif
    .mem_timeout_error(mem_timeout_error)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_err", 32'(mem_timeout_error), 0);
    chk("rst_dhaz", 32'(d_mem_hazard), 0);
    chk("rst_ihaz", 32'(i_mem_hazard), 0);
    chk("rst_dstate", 32'(dut.u_d_wait.state_q), 32'(IDLE));
    tick(); tick();
    reset = 1'b1;
    tick();
    decode_valid = 1; decode_rs1 = 3; decode_rs2 = 5; execute_rd = 5; execute_mem_read = 1; #1;
    chk("lu_rs2", 32'(true_data_hazard), 1);
    decode_rs1 = 5; decode_rs2 = 0; #1;
    chk("lu_rs1", 32'(true_data_hazard), 1);
    execute_rd = 0; decode_rs1 = 0; #1;
    chk("lu_x0", 32'(true_data_hazard), 0);
    execute_rd = 5; decode_rs2 = 5; execute_mem_read = 0; #1;
    chk("lu_noload", 32'(true_data_hazard), 0);
    execute_mem_read = 1; decode_valid = 0; #1;
    chk("lu_novalid", 32'(true_data_hazard), 0);
    execute_mem_read = 0; execute_rd = 0; decode_rs1 = 0; decode_rs2 = 0;
    execute_jalr = 1; #1;
    chk("jalr", 32'(JALR_branch_hazard), 1);
    execute_jalr = 0; execute_branch_taken = 1; #1;
    chk("br_taken", 32'(JALR_branch_hazard), 1);
    execute_branch_taken = 0; decode_jal = 1; decode_valid = 1; #1;
    chk("jal", 32'(JAL_hazard), 1);
    chk("no_jalr", 32'(JALR_branch_hazard), 0);
    decode_valid = 0; #1;
    chk("jal_novalid", 32'(JAL_hazard), 0);
    decode_jal = 0;
    d_mem_req = 1; #1;
    chk("d_w0", 32'(d_mem_hazard), 1);
    tick();
    chk("d_w1", 32'(d_mem_hazard), 1);
    tick();
    chk("d_w2", 32'(d_mem_hazard), 1);
    tick();
    d_mem_resp_valid = 1; #1;
    chk("d_resp", 32'(d_mem_hazard), 0);
    tick();
    d_mem_req = 0; d_mem_resp_valid = 0; #1;
    chk("d_idle_haz", 32'(d_mem_hazard), 0);
    chk("d_idle_state", 32'(dut.u_d_wait.state_q), 32'(IDLE));
    d_mem_req = 1; d_mem_resp_valid = 1; #1;
    chk("d_zero_wait", 32'(d_mem_hazard), 0);
    tick();
    chk("d_zw_state", 32'(dut.u_d_wait.state_q), 32'(IDLE));
    d_mem_req = 0; #1;
    chk("d_resp_noreq", 32'(d_mem_hazard), 0);
    tick();
    chk("d_rnr_state", 32'(dut.u_d_wait.state_q), 32'(IDLE));
    d_mem_resp_valid = 0; d_mem_req = 1;
    tick();
    chk("d_flush_wait", 32'(dut.u_d_wait.state_q), 32'(WAIT));
    d_mem_req = 0;
    tick();
    chk("d_flush_idle", 32'(dut.u_d_wait.state_q), 32'(IDLE));
    chk("d_flush_err", 32'(mem_timeout_error), 0);
    i_mem_req = 1; #1;
    chk("i_t0", 32'(i_mem_hazard), 1);
    tick();
    chk("i_t1", 32'(i_mem_hazard), 1);
    tick();
    chk("i_t2", 32'(i_mem_hazard), 1);
    tick();
    chk("i_t3", 32'(i_mem_hazard), 1);
    chk("i_t3_err", 32'(mem_timeout_error), 0);
    tick();
    chk("i_t4", 32'(i_mem_hazard), 0);
    chk("i_t4_pulse", 32'(dut.i_to), 1);
    tick();
    chk("i_err_set", 32'(mem_timeout_error), 32'h1);
    chk("i_rearm", 32'(i_mem_hazard), 1);
    i_mem_req = 0;
    tick(); tick();
    chk("i_err_sticky", 32'(mem_timeout_error), 32'h1);
    i_mem_req = 1; d_mem_req = 1; #1;
    chk("both_i", 32'(i_mem_hazard), 1);
    chk("both_d", 32'(d_mem_hazard), 1);
    tick();
    chk("both_cnt", 32'(dut.u_i_wait.cnt_q), 1);
    reset = 1'b0; i_mem_req = 0; d_mem_req = 0; #1;
    chk("ar_ihaz", 32'(i_mem_hazard), 0);
    chk("ar_dhaz", 32'(d_mem_hazard), 0);
    chk("ar_err", 32'(mem_timeout_error), 0);
    chk("ar_cnt", 32'(dut.u_i_wait.cnt_q), 0);
    chk("ar_state", 32'(dut.u_d_wait.state_q), 32'(IDLE));
    tick();
    reset = 1'b1;
    tick();
`ifdef HAZARD_STATS_EN
    chk("st_rst", 32'(stat_ctrl), 0);
    execute_jalr = 1;
    for (int i = 0; i < 10; i++) tick();
    execute_jalr = 0; #1;
    chk("st_ctrl10", 32'(stat_ctrl), 10);
    chk("st_lu", 32'(stat_load_use), 0);
    execute_jalr = 1;
    for (int i = 0; i < 10; i++) tick();
    execute_jalr = 0; #1;
    chk("st_sat", 32'(stat_ctrl), 32'hF);
    chk("st_iwait", 32'(stat_i_wait), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
